// File: rtl/ysyx_24100029_ifu_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues one word read at a time
// on a valid/ready memory port and hands {inst, pc} to decode.
// Optional perf counters are built only when IFU_PERF_EN is defined.
//
// state | meaning
// REQ   | request fetch_pc on the memory port
// WAIT  | read accepted, waiting for the single response
// HOLD  | instruction presented to decode until it is taken
module ysyx_24100029_ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  output logic        master_valid,
  input  logic        master_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [31:0] STEP = 32'(PC_STEP);

  state_t      state;
  logic [31:0] fetch_pc;
  logic        kill;
  logic [31:0] redirect_tgt;
  logic        req_fire;
  logic        dec_fire;

  assign redirect_tgt = {redirect_pc[31:2], 2'b00};
  assign req_valid    = (state == S_REQ) && !reset;
  assign req_addr     = fetch_pc;
  assign req_fire     = req_valid && req_ready;
  assign dec_fire     = master_valid && master_ready;

  // Fetch sequencing; a redirect overrides any PC update made the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_REQ;
      fetch_pc     <= RESET_PC;
      kill         <= 1'b0;
      master_valid <= 1'b0;
      inst         <= 32'h0;
      pc           <= 32'h0;
    end else begin
      case (state)
        S_REQ: begin
          if (req_fire) begin
            state <= S_WAIT;
            // the read already in flight now targets a stale PC
            kill  <= redirect_valid;
          end
        end
        S_WAIT: begin
          if (rsp_valid) begin
            kill <= 1'b0;
            if (kill || redirect_valid) begin
              state <= S_REQ;
            end else begin
              inst         <= rsp_data;
              pc           <= fetch_pc;
              master_valid <= 1'b1;
              state        <= S_HOLD;
            end
          end else if (redirect_valid) begin
            kill <= 1'b1;
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            master_valid <= 1'b0;
            state        <= S_REQ;
          end else if (dec_fire) begin
            fetch_pc     <= fetch_pc + STEP;
            master_valid <= 1'b0;
            state        <= S_REQ;
          end
        end
        default: begin
          state        <= S_REQ;
          master_valid <= 1'b0;
        end
      endcase
      if (redirect_valid) begin
        fetch_pc <= redirect_tgt;
      end
    end
  end

`ifdef IFU_PERF_EN
  // Count decode handshakes and cycles decode leaves an instruction waiting.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetch_cnt <= 32'h0;
      perf_stall_cnt <= 32'h0;
    end else begin
      if (dec_fire) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if ((state == S_HOLD) && !master_ready) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`else
  assign perf_fetch_cnt = 32'h0;
  assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_ysyx_24100029_ifu_fetch.sv
// Self-checking bench for ysyx_24100029_ifu_fetch: a directed memory/decode
// model with a scoreboard of instructions decode is expected to receive.
module tb_ysyx_24100029_ifu_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        master_valid;
  logic        master_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;

`ifdef IFU_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } sb_t;

  sb_t sb[$];
  int  total = 0;
  int  bad   = 0;

  ysyx_24100029_ifu_fetch dut (
    .clock          (clock),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .master_valid   (master_valid),
    .master_ready   (master_ready),
    .inst           (inst),
    .pc             (pc),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // decode side: every accepted instruction must match the scoreboard head
  always @(negedge clock) begin
    if (!reset && master_valid && master_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", {31'b0, master_valid}, 32'h0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("sb_inst", inst, e.inst);
        chk("sb_pc", pc, e.pc);
      end
    end
  end

  task automatic req_phase(input logic [31:0] exp_addr);
    int n;
    n = 0;
    req_ready = 1'b1;
    @(negedge clock);
    while (!req_valid && n < 10) begin
      @(posedge clock); #1;
      @(negedge clock);
      n++;
    end
    if (!req_valid) chk("req_timeout", {31'b0, req_valid}, 32'h1);
    chk("req_addr", req_addr, exp_addr);
    @(posedge clock); #1;
    req_ready = 1'b0;
  endtask

  task automatic rsp_phase(input logic [31:0] data, input logic [31:0] addr, input bit push);
    sb_t e;
    rsp_valid = 1'b1;
    rsp_data  = data;
    if (push) begin
      e.inst = data;
      e.pc   = addr;
      sb.push_back(e);
    end
    @(negedge clock);
    chk("wait_no_req", {31'b0, req_valid}, 32'h0);
    @(posedge clock); #1;
    rsp_valid = 1'b0;
  endtask

  task automatic hold_accept(input int delay, input logic [31:0] data, input logic [31:0] addr);
    for (int i = 0; i < delay; i++) begin
      master_ready = 1'b0;
      @(negedge clock);
      chk("hold_mv", {31'b0, master_valid}, 32'h1);
      chk("hold_inst", inst, data);
      chk("hold_pc", pc, addr);
      @(posedge clock); #1;
    end
    master_ready = 1'b1;
    @(negedge clock);
    chk("accept_mv", {31'b0, master_valid}, 32'h1);
    @(posedge clock); #1;
    master_ready = 1'b0;
  endtask

  task automatic fetch_one(input logic [31:0] addr, input int delay);
    logic [31:0] data;
    data = addr ^ 32'h1357_9BDF;
    req_phase(addr);
    rsp_phase(data, addr, 1'b1);
    hold_accept(delay, data, addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data = 32'h0;
    master_ready = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_req_valid", {31'b0, req_valid}, 32'h0);
    chk("rst_mv", {31'b0, master_valid}, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_perf_fetch", perf_fetch_cnt, 32'h0);
    chk("rst_perf_stall", perf_stall_cnt, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;

    // sequential fetches
    fetch_one(32'h3000_0000, 0);
    fetch_one(32'h3000_0004, 0);

    // decode stalls five cycles
    fetch_one(32'h3000_0008, 5);
    chk("perf_fetch3", perf_fetch_cnt, PERF ? 32'd3 : 32'd0);
    chk("perf_stall5", perf_stall_cnt, PERF ? 32'd5 : 32'd0);

    // redirect while waiting, stale response arrives next cycle
    req_phase(32'h3000_000C);
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0010;
    @(posedge clock); #1;
    redirect_valid = 1'b0;
    rsp_phase(32'hDEAD_BEEF, 32'h0, 1'b0);
    @(negedge clock);
    chk("wait_redir_mv", {31'b0, master_valid}, 32'h0);
    chk("wait_redir_addr", req_addr, 32'h8000_0010);
    @(posedge clock); #1;
    fetch_one(32'h8000_0010, 0);

    // redirect in HOLD while decode stalls; low bits of target ignored
    req_phase(32'h8000_0014);
    rsp_phase(32'h0000_0073, 32'h8000_0014, 1'b1);
    master_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0103;
    @(negedge clock);
    chk("hold_redir_mv_before", {31'b0, master_valid}, 32'h1);
    @(posedge clock); #1;
    redirect_valid = 1'b0;
    void'(sb.pop_front());
    @(negedge clock);
    chk("hold_redir_mv", {31'b0, master_valid}, 32'h0);
    chk("hold_redir_addr", req_addr, 32'h8000_0100);
    @(posedge clock); #1;
    fetch_one(32'h8000_0100, 0);

    // redirect in REQ without acceptance, then PC wrap
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    req_ready = 1'b0;
    @(negedge clock);
    chk("req_redir_old", req_addr, 32'h8000_0104);
    @(posedge clock); #1;
    redirect_valid = 1'b0;
    @(negedge clock);
    chk("req_redir_valid", {31'b0, req_valid}, 32'h1);
    chk("req_redir_new", req_addr, 32'hFFFF_FFFC);
    @(posedge clock); #1;
    fetch_one(32'hFFFF_FFFC, 0);
    fetch_one(32'h0000_0000, 0);

    // redirect in the same cycle as request acceptance
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    req_phase(32'h0000_0004);
    redirect_valid = 1'b0;
    rsp_phase(32'hBAD0_0004, 32'h0, 1'b0);
    @(negedge clock);
    chk("acc_redir_mv", {31'b0, master_valid}, 32'h0);
    chk("acc_redir_addr", req_addr, 32'h0000_0100);
    @(posedge clock); #1;

    // reset during WAIT, response afterwards is ignored
    req_phase(32'h0000_0100);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    rsp_valid = 1'b1;
    rsp_data = 32'hCAFE_0100;
    @(negedge clock);
    chk("rstw_req_valid", {31'b0, req_valid}, 32'h1);
    chk("rstw_addr", req_addr, 32'h3000_0000);
    chk("rstw_mv", {31'b0, master_valid}, 32'h0);
    @(posedge clock); #1;
    rsp_valid = 1'b0;
    @(negedge clock);
    chk("rstw_mv2", {31'b0, master_valid}, 32'h0);
    chk("rstw_perf_fetch", perf_fetch_cnt, 32'h0);
    @(posedge clock); #1;
    fetch_one(32'h3000_0000, 0);
    chk("final_perf_fetch", perf_fetch_cnt, PERF ? 32'd1 : 32'd0);
    chk("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
